// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int unsigned PS2_FRAME_BITS = 11;
  // start, parity and stop frame the payload
  localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  function automatic logic ps2_odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter; idles high.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // filt flips only after FILTER_LEN consecutive synchronized samples disagree with it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt  <= '0;
        filt <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver producing scancode events with E0/F0 prefix tracking.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic           clk_f;
  logic           data_f;
  logic           clk_d;
  logic           fe_c;
  ps2_state_e     state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [WDW-1:0] wd;
  logic           pend_ext;
  logic           pend_brk;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2Clk),
    .filt    (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ps2Data),
    .filt    (data_f)
  );

  assign fe_c = clk_d & ~clk_f;

  // Frame FSM, watchdog and frame evaluation; strobes default low every cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_d       <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      wd          <= '0;
      pend_ext    <= 1'b0;
      pend_brk    <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      clk_d      <= clk_f;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state != IDLE && !fe_c && wd == WDW'(TIMEOUT_CYCLES - 1)) begin
        // stalled mid-frame: abandon it and forget any prefix
        state     <= IDLE;
        rx_busy   <= 1'b0;
        frame_err <= 1'b1;
        pend_ext  <= 1'b0;
        pend_brk  <= 1'b0;
        wd        <= '0;
      end else begin
        if (fe_c) begin
          wd <= WDW'(1);
        end else if (state != IDLE) begin
          wd <= wd + WDW'(1);
        end

        case (state)
          IDLE: begin
            if (fe_c && !data_f) begin
              state   <= DATA;
              rx_busy <= 1'b1;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (fe_c) begin
              shreg   <= {data_f, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'(1);
              if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (fe_c) begin
              par_bit <= data_f;
              state   <= STOP;
            end
          end
          STOP: begin
            if (fe_c) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!(ps2_odd_parity_ok(shreg, par_bit) && data_f)) begin
                frame_err <= 1'b1;
                pend_ext  <= 1'b0;
                pend_brk  <= 1'b0;
              end else if (shreg == PS2_PFX_EXT) begin
                pend_ext <= 1'b1;
              end else if (shreg == PS2_PFX_BRK) begin
                pend_brk <= 1'b1;
              end else begin
                code        <= shreg;
                is_extended <= pend_ext;
                is_break    <= pend_brk;
                code_valid  <= 1'b1;
                pend_ext    <= 1'b0;
                pend_brk    <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomized and directed bench for ps2_scancode_rx against a frame-level prefix model.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 25000;
  localparam int HALF       = 24;
  localparam int GAP        = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] code;
  logic       code_valid, is_break, is_extended, frame_err, rx_busy;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int last_cv_cyc = 0, last_fe_cyc = 0, stop_cyc = 0;

  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic       exp_cv, exp_fe, exp_ext, exp_brk;
  logic [7:0] exp_code;
  int         d_cv, d_fe;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .code        (code),
    .code_valid  (code_valid),
    .is_break    (is_break),
    .is_extended (is_extended),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (code_valid) begin cv_cnt++; last_cv_cyc = cyc; end
      if (frame_err) begin fe_cnt++; last_fe_cyc = cyc; end
      if (code_valid && frame_err) both_cnt++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    ps2Data = v;
    wait_neg(HALF);
    ps2Clk = 1'b0;
    wait_neg(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bp, input logic bs);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bp);
    ps2Data = ~bs;
    wait_neg(HALF);
    ps2Clk = 1'b0;
    stop_cyc = cyc;
    wait_neg(HALF);
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    wait_neg(GAP);
  endtask

  // Frame-level reference: prefixes accumulate, bad frames clear them, other bytes emit an event
  task automatic send_model(input logic [7:0] b, input logic bp, input logic bs);
    int cv0, fe0;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    exp_cv = 1'b0;
    exp_fe = 1'b0;
    if (bp || bs) begin
      exp_fe = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_cv = 1'b1;
      exp_code = b;
      exp_ext = m_ext;
      exp_brk = m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    send_frame(b, bp, bs);
    d_cv = cv_cnt - cv0;
    d_fe = fe_cnt - fe0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_neg(4);
    reset_n = 1'b1;
    wait_neg(2);
    total++; if (code !== 8'h00) begin bad++; $display("FAIL reset_code: got %h expected 00", code); end
    total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_code_valid: got %b expected 0", code_valid); end
    total++; if (is_break !== 1'b0) begin bad++; $display("FAIL reset_is_break: got %b expected 0", is_break); end
    total++; if (is_extended !== 1'b0) begin bad++; $display("FAIL reset_is_extended: got %b expected 0", is_extended); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_good_frame;
    send_model(8'h1C, 1'b0, 1'b0);
    total++; if (d_cv != 1) begin bad++; $display("FAIL good_cv_count: got %0d expected 1", d_cv); end
    total++; if (d_fe != 0) begin bad++; $display("FAIL good_fe_count: got %0d expected 0", d_fe); end
    total++; if (code !== 8'h1C) begin bad++; $display("FAIL good_code: got %h expected 1c", code); end
    total++; if ({is_break, is_extended} !== 2'b00) begin bad++; $display("FAIL good_flags: got %b expected 00", {is_break, is_extended}); end
    total++;
    if (last_cv_cyc - stop_cyc != FILTER_LEN + 3) begin
      bad++; $display("FAIL good_latency: got %0d expected %0d", last_cv_cyc - stop_cyc, FILTER_LEN + 3);
    end
  endtask

  task automatic test_prefix;
    int cv0;
    cv0 = cv_cnt;
    send_model(8'hE0, 1'b0, 1'b0);
    send_model(8'hF0, 1'b0, 1'b0);
    total++; if (cv_cnt != cv0) begin bad++; $display("FAIL prefix_silent: got %0d events expected 0", cv_cnt - cv0); end
    send_model(8'h75, 1'b0, 1'b0);
    total++; if (d_cv != 1) begin bad++; $display("FAIL prefix_cv_count: got %0d expected 1", d_cv); end
    total++; if (code !== 8'h75) begin bad++; $display("FAIL prefix_code: got %h expected 75", code); end
    total++; if ({is_break, is_extended} !== {exp_brk, exp_ext}) begin bad++; $display("FAIL prefix_flags: got %b expected %b", {is_break, is_extended}, {exp_brk, exp_ext}); end
    send_model(8'h1C, 1'b0, 1'b0);
    total++; if ({is_break, is_extended} !== {exp_brk, exp_ext}) begin bad++; $display("FAIL prefix_cleared: got %b expected %b", {is_break, is_extended}, {exp_brk, exp_ext}); end
    send_model(8'hE0, 1'b0, 1'b0);
    send_model(8'hE0, 1'b0, 1'b0);
    send_model(8'h6B, 1'b0, 1'b0);
    total++; if ({code, is_break, is_extended} !== {exp_code, exp_brk, exp_ext}) begin bad++; $display("FAIL prefix_repeat: got %h/%b%b expected %h/%b%b", code, is_break, is_extended, exp_code, exp_brk, exp_ext); end
  endtask

  task automatic test_parity_err;
    send_model(8'hF0, 1'b0, 1'b0);
    send_model(8'h1C, 1'b1, 1'b0);
    total++; if (d_fe != 1) begin bad++; $display("FAIL parity_fe_count: got %0d expected 1", d_fe); end
    total++; if (d_cv != 0) begin bad++; $display("FAIL parity_cv_count: got %0d expected 0", d_cv); end
    total++;
    if (last_fe_cyc - stop_cyc != FILTER_LEN + 3) begin
      bad++; $display("FAIL parity_latency: got %0d expected %0d", last_fe_cyc - stop_cyc, FILTER_LEN + 3);
    end
    send_model(8'h1C, 1'b0, 1'b0);
    total++; if ({d_cv, is_break} !== {32'd1, exp_brk}) begin bad++; $display("FAIL parity_prefix_cleared: got %0d/%b expected 1/%b", d_cv, is_break, exp_brk); end
    send_model(8'h33, 1'b0, 1'b1);
    total++; if ({d_fe, d_cv} !== {32'd1, 32'd0}) begin bad++; $display("FAIL stop_err: got fe=%0d cv=%0d expected fe=1 cv=0", d_fe, d_cv); end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    int n;
    logic got, busy_mid;
    b = 8'($urandom);
    got = 1'b0;
    busy_mid = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    ps2Data = b[4];
    wait_neg(HALF);
    ps2Clk = 1'b0;
    n = 0;
    while (!got && n < TIMEOUT + FILTER_LEN + 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == HALF) ps2Clk = 1'b1;
      if (n == 40) busy_mid = rx_busy;
      if (frame_err) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL timeout_seen: got 0 expected 1 within %0d clocks", n); end
    total++; if (n != FILTER_LEN + 2 + TIMEOUT) begin bad++; $display("FAIL timeout_latency: got %0d expected %0d", n, FILTER_LEN + 2 + TIMEOUT); end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL timeout_busy_mid: got %b expected 1", busy_mid); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL timeout_busy_drop: got %b expected 0", rx_busy); end
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2Data = 1'b1;
    wait_neg(GAP);
    send_model(8'h29, 1'b0, 1'b0);
    total++; if ({d_cv, d_fe, code} !== {32'd1, 32'd0, 8'h29}) begin bad++; $display("FAIL timeout_recover: got cv=%0d fe=%0d code=%h expected cv=1 fe=0 code=29", d_cv, d_fe, code); end
  endtask

  task automatic test_glitch;
    int cv0, fe0;
    logic busy_seen;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    busy_seen = 1'b0;
    ps2Data = 1'b0;
    ps2Clk = 1'b0;
    wait_neg(3);
    ps2Clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL glitch_busy: got 1 expected 0"); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL data_low_busy: got 1 expected 0"); end
    ps2Data = 1'b1;
    wait_neg(GAP);
    total++; if ((cv_cnt - cv0) + (fe_cnt - fe0) != 0) begin bad++; $display("FAIL glitch_events: got %0d expected 0", (cv_cnt - cv0) + (fe_cnt - fe0)); end
  endtask

  task automatic test_reset_midframe;
    int cv0, fe0;
    send_model(8'hF0, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    ps2Data = 1'b1;
    wait_neg(1);
    reset_n = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    total++; if ({code, code_valid, is_break, is_extended, frame_err, rx_busy} !== 13'd0) begin bad++; $display("FAIL midreset_outputs: got %h/%b%b%b%b%b expected all zero", code, code_valid, is_break, is_extended, frame_err, rx_busy); end
    wait_neg(GAP);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_model(8'h5A, 1'b0, 1'b0);
    total++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd1, 32'd0}) begin bad++; $display("FAIL midreset_events: got cv=%0d fe=%0d expected cv=1 fe=0", cv_cnt - cv0, fe_cnt - fe0); end
    total++; if ({code, is_break, is_extended} !== {exp_code, exp_brk, exp_ext}) begin bad++; $display("FAIL midreset_decode: got %h/%b%b expected %h/%b%b", code, is_break, is_extended, exp_code, exp_brk, exp_ext); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic bp, bs;
    int r;
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 7));
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 15) == 0);
      send_model(b, bp, bs);
      total++;
      if (d_cv != int'(exp_cv) || d_fe != int'(exp_fe)) begin
        bad++; $display("FAIL rand_events[%0d] byte %h: got cv=%0d fe=%0d expected cv=%0d fe=%0d", k, b, d_cv, d_fe, exp_cv, exp_fe);
      end
      if (exp_cv) begin
        total++;
        if ({code, is_break, is_extended} !== {exp_code, exp_brk, exp_ext}) begin
          bad++; $display("FAIL rand_decode[%0d]: got %h/%b%b expected %h/%b%b", k, code, is_break, is_extended, exp_code, exp_brk, exp_ext);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_prefix();
    test_parity_err();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
